// File: rtl/acs_sequencer_pkg.sv
// Shared widths, state encoding and helpers for the ACS segment sequencer
// of the 256-state Viterbi decoder.
package acs_sequencer_pkg;

    localparam int WD_FSM       = 6;
    localparam int N_SEG        = 2 ** WD_FSM;
    localparam int WD_STATE     = 1;
    localparam int FILL_SYMBOLS = 8;
    localparam int WD_FILL      = 4;

    typedef enum logic [WD_STATE-1:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef logic [WD_FSM-1:0] seg_t;

    function automatic logic is_last_seg(input seg_t seg);
        return seg == seg_t'(N_SEG - 1);
    endfunction

endpackage

// File: rtl/acs_sequencer_if.sv
// Bundle between the branch-metric generator, the ACS sequencer and the ACS
// datapath. master = sequencer, slave = upstream/downstream consumers.
interface acs_sequencer_if;
    import acs_sequencer_pkg::*;

    // Handshake: a symbol transfers on a cycle where SymbolValid and
    // SymbolReady are both 1; SymbolValid may drop the following cycle, but
    // the branch metrics must stay stable for the whole 64-segment sweep.
    logic SymbolValid;
    logic SymbolReady;
    logic Active;
    logic Init;
    logic Hold;
    logic CompareStart;
    seg_t ACSSegment;
    logic SymbolDone;

    modport master (
        input  SymbolValid,
        output SymbolReady, Active, Init, Hold, CompareStart, ACSSegment, SymbolDone
    );

    modport slave (
        output SymbolValid,
        input  SymbolReady, Active, Init, Hold, CompareStart, ACSSegment, SymbolDone
    );

endinterface

// File: rtl/acs_sequencer_fill_tracker.sv
// Counts completed symbols since Restart (saturating) and raises CompareStart
// once the trellis has filled.
module acs_fill_tracker
    import acs_sequencer_pkg::*;
(
    input  logic Clock2,
    input  logic Reset,
    input  logic Restart,
    input  logic Active,
    input  logic Hold,
    output logic CompareStart_o
);

    localparam logic [WD_FILL-1:0] FILL_MAX = WD_FILL'(FILL_SYMBOLS);

    logic [WD_FILL-1:0] fill_q, fill_d;
    logic               cmp_q, cmp_d;

    always_comb begin
        fill_d = fill_q;
        if (Restart) begin
            fill_d = '0;
        end else if (Active && Hold && (fill_q != FILL_MAX)) begin
            fill_d = fill_q + WD_FILL'(1);
        end
        // Registered from the next count so compare opens on segment 0 of the
        // first symbol after the fill, not one segment late.
        cmp_d = (fill_d == FILL_MAX);
    end

    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            fill_q <= '0;
            cmp_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            cmp_q  <= cmp_d;
        end
    end

    assign CompareStart_o = cmp_q;

endmodule

// File: rtl/acs_sequencer.sv
// Per-symbol segment sweep controller for the 4-way ACS unit.
// Optional build macro ACS_SEQ_STALL_EN adds a Stall input that freezes a sweep.
module acs_sequencer
    import acs_sequencer_pkg::*;
(
    input  logic             Clock2,
    input  logic             Reset,
    input  logic             Restart,
`ifdef ACS_SEQ_STALL_EN
    input  logic             Stall,
`endif
    acs_sequencer_if.master  bus,
    output state_t           state_dbg_o
);

    state_t state_q, state_d;
    seg_t   seg_q, seg_d;
    logic   active_q, active_d;
    logic   init_q, init_d;
    logic   hold_q, hold_d;
    logic   done_q, done_d;
    logic   stall_run;
    logic   last_seg;
    logic   ready;
    logic   accept;
    logic   cmp_start;

`ifdef ACS_SEQ_STALL_EN
    assign stall_run = Stall && (state_q == RUN);
`else
    assign stall_run = 1'b0;
`endif

    assign last_seg = (state_q == RUN) && is_last_seg(seg_q);
    assign ready    = ((state_q == IDLE) || last_seg) && !Restart && !stall_run;
    assign accept   = bus.SymbolValid && ready;

    always_comb begin
        state_d = state_q;
        seg_d   = seg_q;
        done_d  = 1'b0;
        if (Restart) begin
            state_d = IDLE;
            seg_d   = '0;
        end else if (!stall_run) begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = RUN;
                        seg_d   = '0;
                    end
                end
                RUN: begin
                    if (last_seg) begin
                        done_d  = 1'b1;
                        seg_d   = '0;
                        state_d = accept ? RUN : IDLE;
                    end else begin
                        seg_d = seg_q + seg_t'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    seg_d   = '0;
                end
            endcase
        end
        active_d = (state_d == RUN);
        init_d   = active_d && (seg_d == '0);
        hold_d   = active_d && is_last_seg(seg_d);
    end

    always_ff @(posedge Clock2 or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            seg_q    <= '0;
            active_q <= 1'b0;
            init_q   <= 1'b0;
            hold_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            seg_q    <= seg_d;
            active_q <= active_d;
            init_q   <= init_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
        end
    end

    // A stalled sweep keeps its registers; only the strobes are masked.
    assign bus.Active      = active_q && !stall_run;
    assign bus.Init        = init_q && !stall_run;
    assign bus.Hold        = hold_q && !stall_run;
    assign bus.SymbolReady = ready;
    assign bus.ACSSegment  = seg_q;
    assign bus.SymbolDone  = done_q;
    assign bus.CompareStart = cmp_start;
    assign state_dbg_o     = state_q;

    acs_fill_tracker u_fill (
        .Clock2         (Clock2),
        .Reset          (Reset),
        .Restart        (Restart),
        .Active         (bus.Active),
        .Hold           (bus.Hold),
        .CompareStart_o (cmp_start)
    );

endmodule

// File: tb/tb_acs_sequencer.sv
// Directed/randomised bench for acs_sequencer against a symbol-level
// reference model; outputs are compared once per cycle on the falling edge.
module tb_acs_sequencer;
    import acs_sequencer_pkg::*;

    localparam int FILL = 8;
    localparam int LAST = 63;

    logic   Clock2  = 1'b0;
    logic   Reset   = 1'b0;
    logic   Restart = 1'b0;
`ifdef ACS_SEQ_STALL_EN
    logic   Stall   = 1'b0;
`endif
    state_t state_dbg;

    acs_sequencer_if bus ();

    acs_sequencer dut (
        .Clock2      (Clock2),
        .Reset       (Reset),
        .Restart     (Restart),
`ifdef ACS_SEQ_STALL_EN
        .Stall       (Stall),
`endif
        .bus         (bus),
        .state_dbg_o (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 Clock2 = ~Clock2;

    // ---------------- reference model ----------------
    // busy: a symbol sweep is in progress; pos: position within the sweep;
    // completed: symbols finished since the last reset/restart (unsaturated).
    int m_busy;
    int m_pos;
    int m_done;
    int m_completed;

    logic [12:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        m_busy = 0; m_pos = 0; m_done = 0; m_completed = 0;
    endtask

    function automatic logic [12:0] model_vec(input logic r);
        logic       rdy;
        logic [5:0] pos6;
        rdy  = ((m_busy == 0) || (m_pos == LAST)) && !r;
        pos6 = 6'(m_pos);
        return {m_busy != 0, rdy, m_busy != 0,
                (m_busy != 0) && (m_pos == 0),
                (m_busy != 0) && (m_pos == LAST),
                m_completed >= FILL, m_done != 0, pos6};
    endfunction

    task automatic model_step(input logic v, input logic r);
        logic acc;
        acc = v && ((m_busy == 0) || (m_pos == LAST)) && !r;
        if (r) begin
            model_reset();
        end else if (m_busy != 0) begin
            if (m_pos == LAST) begin
                m_completed++;
                m_done = 1;
                m_busy = acc ? 1 : 0;
                m_pos  = 0;
            end else begin
                m_pos++;
                m_done = 0;
            end
        end else begin
            m_done = 0;
            if (acc) begin
                m_busy = 1;
                m_pos  = 0;
            end
        end
    endtask

    // ---------------- scoreboard ----------------
    function automatic logic [12:0] dut_vec();
        return {state_dbg == RUN, bus.SymbolReady, bus.Active, bus.Init, bus.Hold,
                bus.CompareStart, bus.SymbolDone, bus.ACSSegment};
    endfunction

    task automatic check(input string tag);
        logic [12:0] e, o;
        e = exp_q.pop_front();
        o = dut_vec();
        n_checks++;
        assert (o === e) n_pass++;
        else $error("FAIL %s t=%0t observed {st,rdy,act,init,hold,cmp,done,seg}=%b expected %b",
                    tag, $time, o, e);
    endtask

    task automatic timeout(input string tag);
        n_checks++;
        $error("FAIL %s timeout observed no target state expected reached", tag);
    endtask

    // ---------------- driver ----------------
    task automatic drive_cycle(input logic v, input logic r, input string tag);
        bus.SymbolValid = v;
        Restart         = r;
        @(negedge Clock2);
        exp_q.push_back(model_vec(r));
        check(tag);
        model_step(v, r);
        @(posedge Clock2);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int budget;
        bus.SymbolValid = 1'b0;
        model_reset();

        // Reset held low: idle, ready.
        #12;
        exp_q.push_back(model_vec(1'b0));
        check("reset_low");
        @(posedge Clock2);
        #1;
        Reset = 1'b1;
        repeat (2) drive_cycle(1'b0, 1'b0, "idle");

        // Single symbol: one-cycle valid pulse, sweep, done, back to idle.
        drive_cycle(1'b1, 1'b0, "single_accept");
        repeat (67) drive_cycle(1'b0, 1'b0, "single");

        // Three symbols back to back, valid dropped before the third ends.
        for (int i = 0; i < 196; i++) drive_cycle(i < 190, 1'b0, "b2b");

        // Trellis fill: 10 symbols after a restart with random valid gaps.
        drive_cycle(1'b1, 1'b1, "restart_idle");
        budget = 3000;
        while (m_completed < 10 && budget > 0) begin
            drive_cycle($urandom_range(0, 3) != 0, 1'b0, "fill");
            budget--;
        end
        if (budget == 0) timeout("fill");

        // Restart at segment 30 of symbol 9, then refill.
        drive_cycle(1'b0, 1'b1, "restart_pre");
        budget = 3000;
        while (!(m_busy != 0 && m_completed == FILL && m_pos == 30) && budget > 0) begin
            drive_cycle($urandom_range(0, 3) != 0, 1'b0, "to_seg30");
            budget--;
        end
        if (budget == 0) timeout("to_seg30");
        drive_cycle(1'b1, 1'b1, "restart_seg30");
        budget = 3000;
        while (m_completed < FILL + 1 && budget > 0) begin
            drive_cycle($urandom_range(0, 3) != 0, 1'b0, "refill");
            budget--;
        end
        if (budget == 0) timeout("refill");

        // Random traffic with occasional restarts (including near boundaries).
        for (int i = 0; i < 800; i++)
            drive_cycle($urandom_range(0, 2) != 0, $urandom_range(0, 149) == 0, "random");

        // Asynchronous reset mid-sweep at segment 17.
        budget = 200;
        while (!(m_busy != 0 && m_pos == 17) && budget > 0) begin
            drive_cycle(1'b1, 1'b0, "to_seg17");
            budget--;
        end
        if (budget == 0) timeout("to_seg17");
        bus.SymbolValid = 1'b0;
        #2;
        Reset = 1'b0;
        #1;
        model_reset();
        exp_q.push_back(model_vec(1'b0));
        check("async_reset");
        @(posedge Clock2);
        #1;
        Reset = 1'b1;
        repeat (3) drive_cycle(1'b0, 1'b0, "after_reset");
        drive_cycle(1'b1, 1'b0, "post_reset_accept");
        repeat (3) drive_cycle(1'b0, 1'b0, "post_reset_run");

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
